// File: rtl/cmp_pkg.sv
// Shared types and limits for the signed comparator slice.
// Result encoding is available for consumers that want a single 2-bit verdict.
package cmp_pkg;

  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_e;

  localparam int CMP_MAX_WIDTH = 64;

  function automatic cmp_res_e cmp_encode(input logic gt, input logic eq);
    cmp_encode = gt ? CMP_GT : (eq ? CMP_EQ : CMP_LT);
  endfunction

endpackage

// File: rtl/comparator_signed_core.sv
// Combinational signed compare of two WIDTH-bit two's-complement operands.
// Latency 0; no flow control.
module comparator_signed_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // One extra bit of headroom so the extreme difference never wraps.
  logic [WIDTH:0] diff;

  always_comb begin
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    lt   = diff[WIDTH];
    eq   = (diff == '0);
    gt   = !lt && !eq;
  end

endmodule

// File: rtl/comparator_signed_param.sv
// Registered signed comparator: c/gt/eq/lt one cycle after an in_valid sample.
// Latency 1; no backpressure, a new result every cycle in_valid is high.
module comparator_signed_param
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             c,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             out_valid
);

  if (WIDTH < 2 || WIDTH > CMP_MAX_WIDTH) begin : g_bad_width
    $error("comparator_signed_param: WIDTH %0d outside 2..%0d", WIDTH, CMP_MAX_WIDTH);
  end

  logic gt_c;
  logic eq_c;
  logic lt_c;
  logic gt_q;
  logic eq_q;
  logic lt_q;
  logic out_valid_q;

  comparator_signed_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a (a),
    .b (b),
    .gt(gt_c),
    .eq(eq_c),
    .lt(lt_c)
  );

  // Flags hold across idle cycles; only out_valid marks a fresh result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        gt_q <= gt_c;
        eq_q <= eq_c;
        lt_q <= lt_c;
      end
    end
  end

  assign c         = gt_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator_signed_param.sv
// Bench for comparator_signed_param (WIDTH=8): integer-compare model plus literal anchors.
module tb_comparator_signed_param;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic         gt;
  logic         eq;
  logic         lt;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  comparator_signed_param #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed integer ordering of the sampled operands.
  logic m_gt, m_eq, m_lt, m_ov;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gt <= 1'b0;
      m_eq <= 1'b0;
      m_lt <= 1'b0;
      m_ov <= 1'b0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        m_gt <= (sa > sb);
        m_eq <= (sa == sb);
        m_lt <= (sa < sb);
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_c", c, m_gt);
    check("model_gt", gt, m_gt);
    check("model_eq", eq, m_eq);
    check("model_lt", lt, m_lt);
    check("model_out_valid", out_valid, m_ov);
  end

  task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vv);
    a        = va;
    b        = vb;
    in_valid = vv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_all(input string tag, input logic ec, input logic egt,
                            input logic eeq, input logic elt, input logic eov);
    check({tag, "_c"}, c, ec);
    check({tag, "_gt"}, gt, egt);
    check({tag, "_eq"}, eq, eeq);
    check({tag, "_lt"}, lt, elt);
    check({tag, "_out_valid"}, out_valid, eov);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    @(negedge clk);
    expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    step(8'h80, 8'h7F, 1'b1);
    expect_all("min_vs_max", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'h7F, 8'h80, 1'b1);
    expect_all("max_vs_min", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h6F, 8'h58, 1'b1);
    expect_all("pos_gt", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'hAF, 8'hFA, 1'b1);
    expect_all("neg_lt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'h80, 8'h80, 1'b1);
    expect_all("eq_neg", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h01, 8'h00, 1'b0);
    expect_all("hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'h80;
        1: rb = 8'h7F;
        2: rb = ra;
        default: ;
      endcase
      step(ra, rb, ($urandom_range(0, 3) != 0));
    end

    // Async reset mid-stream, between edges, with a result in flight.
    step(8'h05, 8'h03, 1'b1);
    expect_all("pre_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    a        = 8'h7F;
    b        = 8'h7F;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    expect_all("post_release_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hF0, 8'h10, 1'b1);
    expect_all("post_release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'h10, 8'hF0, 1'b1);
    expect_all("back_to_back", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
